frame_serializer: RTL and testbench
===================================

// Module: frame_serializer
// PURPOSE
//  Downstream stage of the frame filler. Reads 12-bit words out of the
//  1024-word frame RAM that the filler writes, and shifts them out MSB-first
//  as one continuous serial telemetry stream, paced by a bit-rate strobe.
//  Addresses wrap at the frame end, so the RAM is replayed cyclically.
//  Flags every word boundary and every frame start for the line encoder.
// PARAMETERS
//  WORD_W     12    bits per RAM word, all serialized
//  ADDR_W     10    RAM address width
//  FRAME_LEN  1024  words per frame; address wraps FRAME_LEN-1 -> 0
// PORTS
//  clk            in   1       system clock, all logic on rising edge
//  reset          in   1       asynchronous, active-high; clears all state
//  en             in   1       run request, level-sensitive
//  bitStrobe      in   1       1-clk pulse per output bit period, any spacing >=1 clk
//  inRDAT         in   WORD_W  RAM read data, valid 1 clk after outRDEN
//  outRADR        out  ADDR_W  RAM read address
//  outRDEN        out  1       RAM read enable, 1-clk pulse
//  outSDAT        out  1       serial data bit, registered
//  outWordStrobe  out  1       1-clk pulse when the first bit of a word is driven
//  outFrameStart  out  1       1-clk pulse when the first bit of word 0 is driven
// BEHAVIOUR
//  Reset: every output is 0, state IDLE, bit counter 0, hold register empty.
//  Datapath: hold register (prefetched word, valid flag, "is addr 0" flag),
//   shift register, bit counter bitcnt (remaining bits of the current word).
//  FSM:
//   IDLE : outSDAT=0, outRADR=0. If en=1: outRDEN=1 for 1 clk at addr 0 -> PRIME.
//   PRIME: capture inRDAT into hold (valid=1, zero flag=1).
//          outRADR <= (outRADR+1) mod FRAME_LEN -> RUN.
//   RUN  : strobe with bitcnt>0: outSDAT<=shreg[MSB], shreg<<=1, bitcnt--.
//          strobe with bitcnt==0 and en=1: load. outSDAT<=hold[MSB],
//           shreg<=hold<<1, bitcnt<=WORD_W-1, outWordStrobe=1, outFrameStart=
//           hold zero flag, hold valid<=0, outRDEN=1 at current outRADR.
//           The next clk captures inRDAT into hold (zero flag = address was 0),
//           valid<=1, outRADR increments modulo FRAME_LEN.
//          strobe with bitcnt==0 and en=0: outSDAT<=0, outRADR<=0,
//           hold invalid -> IDLE.
//  - The refill completes in 1 clk and a word spans WORD_W strobes, so the hold
//    register is always valid at the next load. The output never gaps, even at
//    a bitStrobe on every clk.
//  - Strobes in IDLE or PRIME are ignored; outSDAT stays 0.
//  - en=0 mid-word: the current word is completed. en is sampled only at the
//    word boundary. A restart always begins at address 0, keeping frames aligned.
//  - Wrap: the word after FRAME_LEN-1 is word 0. outFrameStart marks it.
//  - outSDAT, outWordStrobe and outFrameStart change only on a bitStrobe clk.
//    The strobes are high for exactly that clk.
//  - reset mid-word: outputs clear asynchronously. The next start is IDLE, addr 0.
//  - Width rule: address arithmetic is ADDR_W bits. The wrap compare uses
//    FRAME_LEN-1, not the natural ADDR_W overflow.
// TESTING
//  1 reset held, random en/strobe -> all outputs 0, outRADR=0, no outRDEN pulse
//  2 RAM[i]=i, en=1, strobe every 4 clk -> serial stream 0x000,0x001,0x002 MSB
//    first; outRADR sequence 0,1,2,3; outWordStrobe every 48 clk
//  3 FRAME_LEN=4, RAM={0xFAD,0x123,0x456,0x789}, strobe every clk -> 48-bit
//    pattern repeats without gaps; outFrameStart every 48 clk, with bit 1 of 0xFAD
//  4 en dropped at bit 5 of word 3 -> word 3 completes, then outSDAT=0;
//    en re-raised -> stream restarts with RAM[0], and outFrameStart pulses
//  5 reset pulsed at bit 7 of word 2 -> outputs 0 within the same clk; after
//    release with en=1 -> outRDEN at addr 0, and first bit = RAM[0][11]
//  6 strobes during IDLE/PRIME (en just raised) -> ignored; first loaded bit
//    appears on the first strobe at least 2 clk after en is sampled

Source files
------------

// File: rtl/frame_serializer_if.sv
// ---------------------------------------------------------------------------
// frame_serializer_if
// Groups the run control, the frame RAM read port and the serial telemetry
// outputs of the frame serializer into one bundle.
//
//   en             run request, level-sensitive (environment -> serializer)
//   bitStrobe      one-clock pulse per output bit period
//   inRDAT         RAM read data, valid one clock after outRDEN
//   outRADR        RAM read address
//   outRDEN        RAM read enable, one-clock pulse
//   outSDAT        serial data bit, MSB of each word first
//   outWordStrobe  one-clock pulse while the first bit of a word is driven
//   outFrameStart  one-clock pulse while the first bit of word 0 is driven
//
// Modports:
//   slave   - the serializer itself
//   master  - the environment (RAM, rate generator, line encoder)
// ---------------------------------------------------------------------------
interface frame_serializer_if #(
  parameter int WORD_W = 12,
  parameter int ADDR_W = 10
);

  logic              en;
  logic              bitStrobe;
  logic [WORD_W-1:0] inRDAT;
  logic [ADDR_W-1:0] outRADR;
  logic              outRDEN;
  logic              outSDAT;
  logic              outWordStrobe;
  logic              outFrameStart;

  modport slave (
    input  en,
    input  bitStrobe,
    input  inRDAT,
    output outRADR,
    output outRDEN,
    output outSDAT,
    output outWordStrobe,
    output outFrameStart
  );

  modport master (
    output en,
    output bitStrobe,
    output inRDAT,
    input  outRADR,
    input  outRDEN,
    input  outSDAT,
    input  outWordStrobe,
    input  outFrameStart
  );

endinterface

// File: rtl/frame_serializer.sv
// ---------------------------------------------------------------------------
// frame_serializer
// Downstream stage of the frame filler. Reads WORD_W-bit words out of the
// frame RAM and shifts them out MSB-first as one continuous serial stream,
// one bit per bitStrobe. The read address wraps from FRAME_LEN-1 to 0, so the
// RAM contents are replayed cyclically. Word and frame boundaries are flagged
// for the line encoder.
//
// Ports:
//   clk    system clock, everything on the rising edge
//   reset  asynchronous, active-high; clears every register
//   bus    frame_serializer_if.slave (see the interface for signal meanings)
//
// Datapath:
//   hold register  - next word, prefetched while the current one shifts out,
//                    with a valid flag and an "it came from address 0" flag
//   shift register - remaining bits of the word being sent
//   bitCnt         - number of bits of the current word still to be sent
// ---------------------------------------------------------------------------
module frame_serializer #(
  parameter int WORD_W    = 12,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 1024
) (
  input logic               clk,
  input logic               reset,
  frame_serializer_if.slave bus
);

  localparam int                CNT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] radr_q, radr_d;
  logic              sdat_q, sdat_d;
  logic              wordStrobe_q, wordStrobe_d;
  logic              frameStart_q, frameStart_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              holdValid_q, holdValid_d;
  logic              holdZero_q, holdZero_d;
  logic              fetchPend_q, fetchPend_d;
  logic              rdEn;
  logic [ADDR_W-1:0] radrNext;

  // Frame wrap uses FRAME_LEN-1 rather than the natural ADDR_W overflow, so
  // frames shorter than the address space replay correctly.
  always_comb begin
    radrNext = (radr_q == LAST_ADDR) ? '0 : radr_q + ADDR_W'(1);
  end

  // Next-state and datapath logic. A word load issues a RAM read for the
  // following word; the data is captured into the hold register one clock
  // later, long before the WORD_W strobes of the current word have elapsed,
  // so the stream never gaps even with a strobe on every clock.
  always_comb begin
    state_d      = state_q;
    radr_d       = radr_q;
    sdat_d       = sdat_q;
    wordStrobe_d = 1'b0;
    frameStart_d = 1'b0;
    shreg_d      = shreg_q;
    bitCnt_d     = bitCnt_q;
    hold_d       = hold_q;
    holdValid_d  = holdValid_q;
    holdZero_d   = holdZero_q;
    fetchPend_d  = 1'b0;
    rdEn         = 1'b0;

    case (state_q)
      IDLE: begin
        sdat_d = 1'b0;
        radr_d = '0;
        if (bus.en) begin
          rdEn    = 1'b1;
          state_d = PRIME;
        end
      end

      PRIME: begin
        hold_d      = bus.inRDAT;
        holdValid_d = 1'b1;
        holdZero_d  = 1'b1;
        radr_d      = radrNext;
        state_d     = RUN;
      end

      RUN: begin
        if (fetchPend_q) begin
          hold_d      = bus.inRDAT;
          holdValid_d = 1'b1;
          holdZero_d  = (radr_q == '0);
          radr_d      = radrNext;
        end

        // en only matters at a word boundary, so a dropped en always lets
        // the current word finish.
        if (bus.bitStrobe) begin
          if (bitCnt_q != '0) begin
            sdat_d   = shreg_q[WORD_W-1];
            shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
            bitCnt_d = bitCnt_q - CNT_W'(1);
          end else if (bus.en && holdValid_q) begin
            sdat_d       = hold_q[WORD_W-1];
            shreg_d      = {hold_q[WORD_W-2:0], 1'b0};
            bitCnt_d     = LAST_BIT;
            wordStrobe_d = 1'b1;
            frameStart_d = holdZero_q;
            holdValid_d  = 1'b0;
            fetchPend_d  = 1'b1;
            rdEn         = 1'b1;
          end else if (!bus.en) begin
            sdat_d      = 1'b0;
            radr_d      = '0;
            holdValid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns to IDLE at address 0 with
  // every output low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      radr_q       <= '0;
      sdat_q       <= 1'b0;
      wordStrobe_q <= 1'b0;
      frameStart_q <= 1'b0;
      shreg_q      <= '0;
      bitCnt_q     <= '0;
      hold_q       <= '0;
      holdValid_q  <= 1'b0;
      holdZero_q   <= 1'b0;
      fetchPend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      radr_q       <= radr_d;
      sdat_q       <= sdat_d;
      wordStrobe_q <= wordStrobe_d;
      frameStart_q <= frameStart_d;
      shreg_q      <= shreg_d;
      bitCnt_q     <= bitCnt_d;
      hold_q       <= hold_d;
      holdValid_q  <= holdValid_d;
      holdZero_q   <= holdZero_d;
      fetchPend_q  <= fetchPend_d;
    end
  end

  // The read enable is decoded from state and inputs so the RAM sees it in
  // the same clock as the decision. It is masked while reset is held, since
  // IDLE with en high would otherwise request a read during reset.
  always_comb begin
    bus.outRDEN       = rdEn & ~reset;
    bus.outRADR       = radr_q;
    bus.outSDAT       = sdat_q;
    bus.outWordStrobe = wordStrobe_q;
    bus.outFrameStart = frameStart_q;
  end

endmodule

// File: tb/tb_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_frame_serializer
// Self-checking bench for frame_serializer, built with a 4-word frame so the
// address wrap is reached quickly. A small RAM model answers read requests,
// a monitor reassembles serial words and compares them against a queue of
// expected words pushed when each run is started.
// ---------------------------------------------------------------------------
module tb_frame_serializer;

  typedef struct packed {
    logic [11:0] word;
    logic        fs;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       st;
    logic       rden;
    logic       sdat;
    logic       ws;
    logic       fs;
    logic [9:0] radr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [11:0] ram [4];

  int   testsRun     = 0;
  int   testsFailed  = 0;
  int   cycle        = 0;
  int   strobeCount  = 0;
  int   wordsInRun   = 0;
  int   lastWs       = 0;
  int   expInterval  = 0;
  int   expRdAddr    = 0;
  int   strobePeriod = -1;
  logic monOn        = 1'b0;
  logic collecting   = 1'b0;
  exp_t expQ [$];
  vec_t vecs [15];

  frame_serializer_if #(.WORD_W(12), .ADDR_W(10)) bus ();

  frame_serializer #(
    .WORD_W   (12),
    .ADDR_W   (10),
    .FRAME_LEN(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 10 ns clock: rising edges at 5, 15, ...; inputs change on falling edges.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic rst, input logic en, input logic st,
                                 input logic rden, input logic sdat, input logic ws,
                                 input logic fs, input logic [9:0] radr);
    vec_t v;
    v.rst = rst; v.en = en; v.st = st;
    v.rden = rden; v.sdat = sdat; v.ws = ws; v.fs = fs; v.radr = radr;
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {bus.outRDEN, bus.outSDAT, bus.outWordStrobe, bus.outFrameStart, bus.outRADR};
  endfunction

  // Drives one table vector on a falling edge and checks the outputs 1 ns later.
  task automatic applyStimulus(input int idx);
    @(negedge clk);
    reset         = vecs[idx].rst;
    bus.en        = vecs[idx].en;
    bus.bitStrobe = vecs[idx].st;
    #1;
    checkOutput($sformatf("vec%0d", idx), 32'(outs()),
                32'({vecs[idx].rden, vecs[idx].sdat, vecs[idx].ws, vecs[idx].fs, vecs[idx].radr}));
  endtask

  task automatic strobeGen();
    int ph = 0;
    forever begin
      @(negedge clk);
      if (strobePeriod > 0) begin
        bus.bitStrobe = (ph == 0);
        ph = (ph + 1 >= strobePeriod) ? 0 : ph + 1;
      end else begin
        ph = 0;
      end
    end
  endtask

  // RAM model plus output monitor/scoreboard.
  task automatic monitor();
    logic        stAtEdge;
    logic        rdenAtEdge;
    logic [9:0]  radrAtEdge;
    logic [11:0] acc;
    int          nBits;
    logic        fsGot;
    logic        prevSdat;
    exp_t        cur;
    acc = '0; nBits = 0; fsGot = 1'b0; prevSdat = 1'b0; cur = '0;
    forever begin
      @(negedge clk);
      #4;
      stAtEdge   = bus.bitStrobe;
      rdenAtEdge = bus.outRDEN;
      radrAtEdge = bus.outRADR;
      if (monOn && rdenAtEdge) begin
        checkOutput("readAddr", 32'(radrAtEdge), 32'(expRdAddr));
        expRdAddr = (expRdAddr + 1) % 4;
      end
      @(posedge clk);
      #1;
      cycle++;
      if (stAtEdge) strobeCount++;
      bus.inRDAT = rdenAtEdge ? ram[radrAtEdge[1:0]] : 12'($urandom);
      if (reset) begin
        collecting = 1'b0;
      end else if (monOn) begin
        if (bus.outFrameStart) checkOutput("frameWithWord", 32'(bus.outWordStrobe), 1);
        if (bus.outWordStrobe) begin
          checkOutput("wordOnStrobe", 32'(stAtEdge), 1);
          checkOutput("wordComplete", 32'(collecting), 0);
          if (wordsInRun > 0) checkOutput("wordInterval", 32'(cycle - lastWs), 32'(expInterval));
          lastWs = cycle;
          wordsInRun++;
          if (expQ.size() == 0) begin
            checkOutput("unexpectedWord", 32'(expQ.size()), 1);
            collecting = 1'b0;
          end else begin
            cur        = expQ.pop_front();
            collecting = 1'b1;
            acc        = {11'd0, bus.outSDAT};
            nBits      = 1;
            fsGot      = bus.outFrameStart;
          end
        end else if (stAtEdge) begin
          if (collecting) begin
            acc = {acc[10:0], bus.outSDAT};
            nBits++;
          end else begin
            checkOutput("idleSdat", 32'(bus.outSDAT), 0);
          end
        end else begin
          checkOutput("sdatHold", 32'(bus.outSDAT), 32'(prevSdat));
        end
        if (collecting && nBits == 12) begin
          checkOutput("wordData", 32'(acc), 32'(cur.word));
          checkOutput("frameStart", 32'(fsGot), 32'(cur.fs));
          collecting = 1'b0;
        end
      end
      prevSdat = bus.outSDAT;
    end
  endtask

  task automatic waitWords(input int n, input int budget);
    int k = 0;
    while (wordsInRun < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("waitWords", 32'(wordsInRun >= n), 1);
  endtask

  task automatic waitStrobes(input int target, input int budget);
    int k = 0;
    while (strobeCount < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("waitStrobes", 32'(strobeCount >= target), 1);
  endtask

  task automatic pushWords(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.word = ram[k % 4];
      e.fs   = (k % 4 == 0);
      expQ.push_back(e);
    end
  endtask

  task automatic startRun(input int period, input int n);
    strobePeriod = period;
    expInterval  = 12 * period;
    wordsInRun   = 0;
    expRdAddr    = 0;
    pushWords(n);
    @(negedge clk);
    bus.en = 1'b1;
  endtask

  // Waits for the n-th word, drops en while that word's bit dropBit is on
  // the line, then lets the word finish and checks the return to idle.
  task automatic finishRun(input int n, input int dropBit);
    int base;
    waitWords(n, (n + 2) * 12 * strobePeriod + 20);
    base = strobeCount;
    waitStrobes(base + dropBit - 1, 12 * strobePeriod + 10);
    bus.en = 1'b0;
    waitStrobes(base + 14, 16 * strobePeriod + 10);
    checkOutput("queueDrained", 32'(expQ.size()), 0);
    checkOutput("lastWordDone", 32'(collecting), 0);
    checkOutput("idleSdat", 32'(bus.outSDAT), 0);
    checkOutput("idleAddr", 32'(bus.outRADR), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.bitStrobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    clk = 1'b0;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.bitStrobe = 1'b0;
    bus.inRDAT = '0;
    ram = '{12'hFAD, 12'h123, 12'h456, 12'h789};

    // Cycle-by-cycle vectors: reset, idle, start-up latency, first bits.
    vecs[0]  = mkVec(1, 1, 1, 0, 0, 0, 0, 10'd0);
    vecs[1]  = mkVec(1, 0, 1, 0, 0, 0, 0, 10'd0);
    vecs[2]  = mkVec(1, 1, 0, 0, 0, 0, 0, 10'd0);
    vecs[3]  = mkVec(0, 0, 1, 0, 0, 0, 0, 10'd0);
    vecs[4]  = mkVec(0, 1, 1, 1, 0, 0, 0, 10'd0);
    vecs[5]  = mkVec(0, 1, 1, 0, 0, 0, 0, 10'd0);
    vecs[6]  = mkVec(0, 1, 1, 1, 0, 0, 0, 10'd1);
    vecs[7]  = mkVec(0, 1, 0, 0, 1, 1, 1, 10'd1);
    vecs[8]  = mkVec(0, 1, 1, 0, 1, 0, 0, 10'd2);
    vecs[9]  = mkVec(0, 0, 0, 0, 1, 0, 0, 10'd2);
    vecs[10] = mkVec(0, 0, 1, 0, 1, 0, 0, 10'd2);
    vecs[11] = mkVec(0, 0, 1, 0, 1, 0, 0, 10'd2);
    vecs[12] = mkVec(0, 0, 1, 0, 1, 0, 0, 10'd2);
    vecs[13] = mkVec(0, 0, 1, 0, 1, 0, 0, 10'd2);
    vecs[14] = mkVec(0, 0, 0, 0, 0, 0, 0, 10'd2);

    fork
      monitor();
      strobeGen();
      begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
        $fatal(1);
      end
    join_none

    // Reset held with random en/strobe: everything stays quiet.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.en        = 1'($urandom);
      bus.bitStrobe = 1'($urandom);
      #1;
      checkOutput("resetHeld", 32'(outs()), 0);
    end

    for (int i = 0; i < 15; i++) applyStimulus(i);

    doReset();
    monOn = 1'b1;

    // Incrementing RAM, strobe every 4 clocks.
    ram = '{12'h000, 12'h001, 12'h002, 12'h003};
    startRun(4, 4);
    finishRun(4, 1);

    // Strobe every clock across two frame wraps.
    ram = '{12'hFAD, 12'h123, 12'h456, 12'h789};
    startRun(1, 10);
    finishRun(10, 1);

    // en dropped at bit 5 of word 3, then a restart from word 0.
    startRun(2, 4);
    finishRun(4, 5);
    startRun(3, 2);
    finishRun(2, 1);

    // Reset pulsed at bit 7 of word 2, restart with en still high.
    startRun(2, 3);
    waitWords(3, 5 * 24 + 20);
    base = strobeCount;
    waitStrobes(base + 6, 40);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("resetMidWord", 32'(outs()), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("resetQueue", 32'(expQ.size()), 0);
    wordsInRun = 0;
    expRdAddr  = 0;
    pushWords(2);
    reset = 1'b0;
    #1;
    checkOutput("restartRead", 32'({bus.outRDEN, bus.outRADR}), 32'({1'b1, 10'd0}));
    finishRun(2, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
